// File: rtl/eci_pkt_framer.sv
// ECI word-stream framer: derives packet length from the header dmask, tags each
// word with first/last/idx/len, flags disagreement with upstream last, counts packets.
//
//   state | meaning
//   HDR   | next accepted word is a command header; length decoded from its dmask
//   PAY   | inside a packet; 'remaining' payload words still expected
module eci_pkt_framer #(
    parameter int WORD_WIDTH    = 64,
    parameter int DMASK_LSB     = 0,
    parameter int DMASK_WIDTH   = 4,
    parameter int WORDS_PER_SCL = 4,
    parameter int LEN_WIDTH     = 5,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WORD_WIDTH-1:0] m_data,
    output logic                  m_first,
    output logic                  m_last,
    output logic [LEN_WIDTH-1:0]  m_idx,
    output logic [LEN_WIDTH-1:0]  m_len,
    output logic                  err_len,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam int PW = $clog2(DMASK_WIDTH + 1);

    localparam logic ST_HDR = 1'b0;
    localparam logic ST_PAY = 1'b1;

    logic                   state;
    logic [LEN_WIDTH-1:0]   remaining;

    logic                   accept;
    logic                   out_done;
    logic [DMASK_WIDTH-1:0] dmask;
    logic [PW-1:0]          pop;
    logic [LEN_WIDTH-1:0]   hdr_len;

    logic                   comp_last;
    logic                   mismatch;
    logic                   word_last;
    logic                   next_state;
    logic [LEN_WIDTH-1:0]   next_idx;
    logic [LEN_WIDTH-1:0]   next_len;
    logic [LEN_WIDTH-1:0]   next_rem;

    assign s_ready  = !m_valid || m_ready;
    assign accept   = s_valid && s_ready;
    assign out_done = m_valid && m_ready && m_last;
    assign dmask    = s_data[DMASK_LSB +: DMASK_WIDTH];

    always_comb begin
        pop = '0;
        for (int i = 0; i < DMASK_WIDTH; i++) begin
            pop = pop + PW'(dmask[i]);
        end
    end

    assign hdr_len = LEN_WIDTH'(1) + LEN_WIDTH'(WORDS_PER_SCL) * LEN_WIDTH'(pop);

    always_comb begin
        next_idx  = '0;
        next_len  = hdr_len;
        next_rem  = remaining;
        comp_last = 1'b0;
        if (state == ST_HDR) begin
            next_idx  = '0;
            next_len  = hdr_len;
            next_rem  = hdr_len - LEN_WIDTH'(1);
            comp_last = (hdr_len == LEN_WIDTH'(1));
        end else begin
            next_idx  = m_idx + LEN_WIDTH'(1);
            next_len  = m_len;
            next_rem  = remaining - LEN_WIDTH'(1);
            comp_last = (remaining == LEN_WIDTH'(1));
        end
        mismatch  = (s_last != comp_last);
        // An early upstream last truncates the packet so framing resyncs to upstream.
        word_last = comp_last || s_last;
        next_state = word_last ? ST_HDR : ST_PAY;
        if (word_last) begin
            next_rem = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_HDR;
            remaining <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_first   <= 1'b0;
            m_last    <= 1'b0;
            m_idx     <= '0;
            m_len     <= '0;
            err_len   <= 1'b0;
            pkt_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            err_len <= accept && mismatch;
            if (accept) begin
                m_valid   <= 1'b1;
                m_data    <= s_data;
                m_first   <= (state == ST_HDR);
                m_last    <= word_last;
                m_idx     <= next_idx;
                m_len     <= next_len;
                state     <= next_state;
                remaining <= next_rem;
                if (mismatch) begin
                    err_cnt <= err_cnt + CNT_WIDTH'(1);
                end
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (out_done) begin
                pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_eci_pkt_framer.sv
// Self-checking bench for eci_pkt_framer: directed scenarios plus randomized
// packets, checked every cycle against a queue-based framing model.
module tb_eci_pkt_framer;

    localparam int WW  = 64;
    localparam int LW  = 5;
    localparam int CW  = 32;
    localparam int WPS = 4;

    logic          aclk;
    logic          aresetn;
    logic          s_valid;
    logic          s_ready;
    logic [WW-1:0] s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [WW-1:0] m_data;
    logic          m_first;
    logic          m_last;
    logic [LW-1:0] m_idx;
    logic [LW-1:0] m_len;
    logic          err_len;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] err_cnt;

    eci_pkt_framer dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_first (m_first),
        .m_last  (m_last),
        .m_idx   (m_idx),
        .m_len   (m_len),
        .err_len (err_len),
        .pkt_cnt (pkt_cnt),
        .err_cnt (err_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [WW-1:0] data;
        logic          first;
        logic          last;
        int            idx;
        int            len;
        logic          err;
    } beat_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_q[$];
    bit    in_pkt;
    int    cur_len;
    int    cur_idx;
    int    mdl_pkt;
    int    mdl_err;
    bit    prev_accept;
    int    err_pulses;
    int    stall_cnt;
    int    hs_beats;
    int    last_hs_len;
    int    last_hs_idx;
    int    last_hs_first;
    int    rdy_mode = 0;
    int    cyc = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process and reference model, evaluated on every falling edge.
    always @(negedge aclk) begin
        beat_t b;
        beat_t h;
        bit    comp_last;
        if (!aresetn) begin
            exp_q.delete();
            in_pkt = 0; cur_len = 0; cur_idx = 0;
            mdl_pkt = 0; mdl_err = 0; prev_accept = 0;
            err_pulses = 0; stall_cnt = 0; hs_beats = 0;
            check_eq("reset_m_valid", {63'd0, m_valid}, 64'd0);
            check_eq("reset_fields", {m_first, m_last, m_idx, m_len, err_len}, 64'd0);
            check_eq("reset_m_data", m_data, 64'd0);
            check_eq("reset_counters", {pkt_cnt, err_cnt}, 64'd0);
        end else begin
            check_eq("m_valid", {63'd0, m_valid}, {63'd0, exp_q.size() != 0});
            if (m_valid && exp_q.size() != 0) begin
                h = exp_q[0];
                check_eq("m_data", m_data, h.data);
                check_eq("m_first", {63'd0, m_first}, {63'd0, h.first});
                check_eq("m_last", {63'd0, m_last}, {63'd0, h.last});
                check_eq("m_idx", 64'(m_idx), 64'(h.idx));
                check_eq("m_len", 64'(m_len), 64'(h.len));
            end
            if (prev_accept && exp_q.size() != 0)
                check_eq("err_len_new", {63'd0, err_len}, {63'd0, exp_q[$].err});
            else
                check_eq("err_len_idle", {63'd0, err_len}, 64'd0);
            check_eq("s_ready", {63'd0, s_ready}, {63'd0, (!m_valid || m_ready)});
            check_eq("pkt_cnt", 64'(pkt_cnt), 64'(mdl_pkt));
            check_eq("err_cnt", 64'(err_cnt), 64'(mdl_err));

            if (err_len) err_pulses++;
            if (s_valid && !s_ready) stall_cnt++;

            if (m_valid && m_ready && exp_q.size() != 0) begin
                h = exp_q.pop_front();
                hs_beats++;
                last_hs_len   = int'(m_len);
                last_hs_idx   = int'(m_idx);
                last_hs_first = int'(m_first);
                if (h.last) mdl_pkt++;
            end

            prev_accept = s_valid && s_ready;
            if (prev_accept) begin
                b.data = s_data;
                if (!in_pkt) begin
                    cur_len = 1 + WPS * $countones(s_data[3:0]);
                    cur_idx = 0;
                    b.first = 1'b1;
                end else begin
                    cur_idx++;
                    b.first = 1'b0;
                end
                comp_last = (cur_idx == cur_len - 1);
                b.err  = (s_last != comp_last);
                b.last = comp_last || s_last;
                b.idx  = cur_idx;
                b.len  = cur_len;
                in_pkt = !b.last;
                if (b.err) mdl_err++;
                exp_q.push_back(b);
            end
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            cyc++;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: m_ready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    task automatic send_word(input logic [WW-1:0] d, input logic l);
        int budget;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        budget  = 0;
        forever begin
            @(negedge aclk);
            if (s_ready) break;
            budget++;
            if (budget > 1000) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: s_ready stuck low, expected high within 1000 cycles");
                break;
            end
        end
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [3:0] dm, input int nwords, input int last_at);
        for (int i = 0; i < nwords; i++) begin
            logic [WW-1:0] d;
            d = {$urandom, $urandom};
            if (i == 0) d[3:0] = dm;
            send_word(d, (i == last_at));
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(posedge aclk);
            budget++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d beats still pending, expected 0", exp_q.size());
        end
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        aresetn = 1'b0;
        #2;
        check_eq("reset_async_valid", {63'd0, m_valid}, 64'd0);
        do_reset();

        // header-only packet
        rdy_mode = 0;
        send_pkt(4'b0000, 1, 0);
        drain();
        check_eq("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
        check_eq("t1_len", 64'(last_hs_len), 64'd1);
        check_eq("t1_err_pulses", 64'(err_pulses), 64'd0);

        // full 17-word packet at full rate
        do_reset();
        send_pkt(4'b1111, 17, 16);
        drain();
        check_eq("t2_pkt_cnt", 64'(pkt_cnt), 64'd1);
        check_eq("t2_len", 64'(last_hs_len), 64'd17);
        check_eq("t2_last_idx", 64'(last_hs_idx), 64'd16);
        check_eq("t2_beats", 64'(hs_beats), 64'd17);
        check_eq("t2_no_stall", 64'(stall_cnt), 64'd0);

        // backpressure pattern
        do_reset();
        rdy_mode = 1;
        send_pkt(4'b0101, 9, 8);
        drain();
        rdy_mode = 0;
        check_eq("t3_pkt_cnt", 64'(pkt_cnt), 64'd1);
        check_eq("t3_beats", 64'(hs_beats), 64'd9);
        check_eq("t3_stall_seen", {63'd0, stall_cnt != 0}, 64'd1);
        check_eq("t3_last_idx", 64'(last_hs_idx), 64'd8);

        // early upstream last, then a header
        do_reset();
        send_pkt(4'b0011, 5, 4);
        send_pkt(4'b0000, 1, 0);
        drain();
        check_eq("t4_err_cnt", 64'(err_cnt), 64'd1);
        check_eq("t4_err_pulses", 64'(err_pulses), 64'd1);
        check_eq("t4_pkt_cnt", 64'(pkt_cnt), 64'd2);
        check_eq("t4_hdr_first", 64'(last_hs_first), 64'd1);

        // missing upstream last, then a header
        do_reset();
        send_pkt(4'b0001, 5, 99);
        send_pkt(4'b0000, 1, 0);
        drain();
        check_eq("t5_err_cnt", 64'(err_cnt), 64'd1);
        check_eq("t5_pkt_cnt", 64'(pkt_cnt), 64'd2);
        check_eq("t5_hdr_idx", 64'(last_hs_idx), 64'd0);

        // reset mid-packet at idx 3
        do_reset();
        send_pkt(4'b1111, 4, 99);
        check_eq("t6_idx_before", 64'(m_idx), 64'd3);
        #1;
        aresetn = 1'b0;
        #1;
        check_eq("t6_async_valid", {63'd0, m_valid}, 64'd0);
        check_eq("t6_async_fields", {m_first, m_last, m_idx, m_len}, 64'd0);
        check_eq("t6_async_data", m_data, 64'd0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        send_pkt(4'b0000, 1, 0);
        drain();
        check_eq("t6_first", 64'(last_hs_first), 64'd1);
        check_eq("t6_idx", 64'(last_hs_idx), 64'd0);
        check_eq("t6_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // randomized traffic with random backpressure and framing faults
        do_reset();
        rdy_mode = 2;
        for (int p = 0; p < 200; p++) begin
            logic [3:0] dm;
            int len;
            int kind;
            int gap;
            dm   = 4'($urandom_range(0, 15));
            len  = 1 + WPS * $countones(dm);
            kind = $urandom_range(0, 7);
            gap  = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge aclk);
                #1;
            end
            if (kind == 0 && len > 1) begin
                int k;
                k = $urandom_range(0, len - 2);
                send_pkt(dm, k + 1, k);
            end else if (kind == 1) begin
                send_pkt(dm, len, 99);
            end else begin
                send_pkt(dm, len, len - 1);
            end
        end
        drain();
        rdy_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
